// File: rtl/out_uart_tx_if.sv
// Byte-push handshake between the execute stage and the UART output unit.
// The master drives out_req/out_data; out_busy tells it to stall.
interface out_uart_tx_if;
  logic       out_req;
  logic [7:0] out_data;
  logic       out_busy;

  modport master (
    output out_req,
    output out_data,
    input  out_busy
  );

  modport slave (
    input  out_req,
    input  out_data,
    output out_busy
  );
endinterface

// File: rtl/out_uart_tx.sv
// Output unit: buffers OUT bytes in a small FIFO and serialises them 8N1 on txd.
// Optional OUT_DROP_CNT_EN adds a saturating counter of pushes rejected while full.
module out_uart_tx #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH_LOG2  = 3
) (
  input  logic           clk,
  input  logic           rstn,
  out_uart_tx_if.slave   out_if,
  output logic           txd
`ifdef OUT_DROP_CNT_EN
  ,
  output logic [15:0]    drop_cnt
`endif
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int BAUD_W = $clog2(CLK_PER_BIT);
  localparam logic [BAUD_W-1:0]   BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [BAUD_W-1:0]   BAUD_ONE  = BAUD_W'(1);
  localparam logic [DEPTH_LOG2:0] CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                state_reg, state_next;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic [7:0]            shift_reg, shift_next;
  logic [BAUD_W-1:0]     baud_reg, baud_next;
  logic [2:0]            bit_idx_reg, bit_idx_next;
  logic                  txd_reg, txd_next;
  logic                  busy, push, pop, baud_done, have_data;

  // Busy depends only on the registered count, so a pop in the same cycle
  // cannot admit a push that was already judged against a full FIFO.
  assign busy            = (count_reg == CNT_FULL);
  assign out_if.out_busy = busy;
  assign push            = out_if.out_req && !busy;
  assign have_data       = (count_reg != '0);
  assign baud_done       = (baud_reg == BAUD_LAST);
  assign txd             = txd_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= out_if.out_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= S_IDLE;
      shift_reg   <= '0;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      txd_reg     <= 1'b1;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      txd_reg     <= txd_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (have_data) state_next = S_START;
      S_START: if (baud_done) state_next = S_DATA;
      S_DATA:  if (baud_done && bit_idx_reg == 3'd7) state_next = S_STOP;
      S_STOP:  if (baud_done) state_next = have_data ? S_START : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pop          = 1'b0;
    shift_next   = shift_reg;
    baud_next    = baud_done ? '0 : baud_reg + BAUD_ONE;
    bit_idx_next = bit_idx_reg;
    case (state_reg)
      S_IDLE: begin
        baud_next = '0;
        if (have_data) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr_reg];
        end
      end
      S_START: begin
        if (baud_done) bit_idx_next = '0;
      end
      S_DATA: begin
        if (baud_done) begin
          shift_next   = shift_reg >> 1;
          bit_idx_next = bit_idx_reg + 3'd1;
        end
      end
      S_STOP: begin
        // Popping on the last stop cycle keeps back-to-back frames gapless.
        if (baud_done && have_data) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr_reg];
        end
      end
      default: ;
    endcase

    // txd is registered, so it is derived from where the FSM is heading.
    case (state_next)
      S_START: txd_next = 1'b0;
      S_DATA:  txd_next = shift_next[0];
      default: txd_next = 1'b1;
    endcase
  end

`ifdef OUT_DROP_CNT_EN
  logic [15:0] drop_cnt_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt_reg <= '0;
    end else if (out_if.out_req && busy && drop_cnt_reg != 16'hFFFF) begin
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: a per-cycle waveform model of the FIFO and the 8N1 line,
// compared every cycle, plus hand-computed pins on selected cycles.
module tb_out_uart_tx;
  localparam int CPB   = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;

  logic clk;
  logic rstn;
  logic txd;
`ifdef OUT_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  out_uart_tx_if u_if ();

  out_uart_tx #(
    .CLK_PER_BIT (CPB),
    .DEPTH_LOG2  (DL2)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .out_if   (u_if),
    .txd      (txd)
`ifdef OUT_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic txd_log [0:8191];

  // Behavioural model: queued bytes plus the line waveform still owed.
  logic [7:0] m_fifo [$];
  bit         m_wave [$];
  bit         m_txd = 1'b1;
  int         m_drop = 0;
  int         m_accepted = 0;
  logic       m_busy_pre;
  logic [7:0] m_byte;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_fifo.delete();
      m_wave.delete();
      m_txd  = 1'b1;
      m_drop = 0;
    end else begin
      m_busy_pre = (m_fifo.size() == DEPTH);
      if (m_wave.size() == 0 && m_fifo.size() != 0) begin
        m_byte = m_fifo.pop_front();
        for (int i = 0; i < CPB; i++) m_wave.push_back(1'b0);
        for (int b = 0; b < 8; b++)
          for (int i = 0; i < CPB; i++) m_wave.push_back(m_byte[b]);
        for (int i = 0; i < CPB; i++) m_wave.push_back(1'b1);
      end
      if (u_if.out_req) begin
        if (!m_busy_pre) begin
          m_fifo.push_back(u_if.out_data);
          m_accepted++;
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
      m_txd = (m_wave.size() != 0) ? m_wave.pop_front() : 1'b1;
    end
  end

  logic exp_busy;
  always @(negedge clk) begin
    if (cyc < 8192) txd_log[cyc] = txd;
    exp_busy = (m_fifo.size() == DEPTH);
    total++;
    if (txd !== m_txd) begin
      bad++;
      $display("FAIL txd cyc=%0d got=%b exp=%b", cyc, txd, m_txd);
    end
    total++;
    if (u_if.out_busy !== exp_busy) begin
      bad++;
      $display("FAIL out_busy cyc=%0d got=%b exp=%b", cyc, u_if.out_busy, exp_busy);
    end
`ifdef OUT_DROP_CNT_EN
    total++;
    if (drop_cnt !== 16'(m_drop)) begin
      bad++;
      $display("FAIL drop_cnt cyc=%0d got=%0d exp=%0d", cyc, drop_cnt, m_drop);
    end
`endif
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end else begin
      $display("ok %s = %0d", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n = 0;
    while ((m_fifo.size() != 0 || m_wave.size() != 0) && n < max_cycles) begin
      step();
      n++;
    end
    total++;
    if (n >= max_cycles) begin
      bad++;
      $display("FAIL %s drain timeout got=%0d exp<%0d cycles", name, n, max_cycles);
    end else begin
      $display("ok %s drained in %0d cycles", name, n);
    end
    repeat (4) step();
  endtask

  // Hand-computed line for 8'hA5 pushed in cycle 0: start 2-5, bits LSB first, stop 38-41.
  localparam int NA5 = 14;
  int pin_a5_k [NA5] = '{1, 2, 5, 6, 10, 14, 18, 22, 26, 30, 34, 37, 38, 41};
  bit pin_a5_v [NA5] = '{1, 0, 0, 1, 0,  1,  0,  0,  1,  0,  1,  1,  1,  1};

  // 8'h00 then 8'hFF pushed in cycles 0 and 1: frames at 2-41 and 42-81.
  localparam int NZF = 9;
  int pin_zf_k [NZF] = '{2, 20, 37, 38, 41, 42, 46, 77, 78};
  bit pin_zf_v [NZF] = '{0, 0,  0,  1,  1,  0,  1,  1,  1};

  logic [7:0] burst [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    int c0;
    int base;
    int n;
    logic [7:0] dval;

    rstn          = 1'b0;
    u_if.out_req  = 1'b0;
    u_if.out_data = 8'h00;
    repeat (3) step();
    rstn = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 100; i++) begin
      step();
      check("idle_txd", txd, 1);
      check("idle_busy", u_if.out_busy, 0);
    end

    // Single byte A5.
    c0 = cyc;
    u_if.out_req  = 1'b1;
    u_if.out_data = 8'hA5;
    step();
    u_if.out_req = 1'b0;
    repeat (45) step();
    for (int i = 0; i < NA5; i++)
      check($sformatf("a5_txd_cycle%0d", pin_a5_k[i]), txd_log[c0 + pin_a5_k[i]], pin_a5_v[i]);

    // Transmitter busy with 3C, then five consecutive pushes: fifth is rejected.
    u_if.out_req  = 1'b1;
    u_if.out_data = 8'h3C;
    step();
    u_if.out_req = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("burst_busy_before_push%0d", i), u_if.out_busy, (i == 4) ? 1 : 0);
      u_if.out_req  = 1'b1;
      u_if.out_data = burst[i];
      step();
    end
    u_if.out_req = 1'b0;
    check("burst_busy_after", u_if.out_busy, 1);
`ifdef OUT_DROP_CNT_EN
    check("burst_drop_cnt", drop_cnt, 1);
`endif
    drain("burst", 400);

    // All-zero and all-one frames back to back.
    c0 = cyc;
    u_if.out_req  = 1'b1;
    u_if.out_data = 8'h00;
    step();
    u_if.out_data = 8'hFF;
    step();
    u_if.out_req = 1'b0;
    drain("zero_ff", 200);
    for (int i = 0; i < NZF; i++)
      check($sformatf("zf_txd_cycle%0d", pin_zf_k[i]), txd_log[c0 + pin_zf_k[i]], pin_zf_v[i]);

    // Reset in the middle of a data bit with three bytes queued.
    for (int i = 0; i < 4; i++) begin
      u_if.out_req  = 1'b1;
      u_if.out_data = 8'h81 + 8'(i);
      step();
    end
    u_if.out_req = 1'b0;
    repeat (12) step();
    #1 rstn = 1'b0;
    #1;
    check("rst_txd_immediate", txd, 1);
    check("rst_busy_immediate", u_if.out_busy, 0);
`ifdef OUT_DROP_CNT_EN
    check("rst_drop_cnt", drop_cnt, 0);
`endif
    repeat (2) step();
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      check("post_rst_txd", txd, 1);
    end

    // Sustained requests against a full FIFO: pointers wrap many times.
    base = m_accepted;
    dval = 8'h40;
    n = 0;
    u_if.out_req = 1'b1;
    while (m_accepted - base < 26 && n < 3000) begin
      u_if.out_data = dval;
      step();
      dval = dval + 8'd7;
      n++;
    end
    u_if.out_req = 1'b0;
    check("wrap_accepted_in_budget", (n < 3000) ? 1 : 0, 1);
    drain("wrap", 400);
    check("wrap_final_busy", u_if.out_busy, 0);
    check("wrap_final_txd", txd, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
